// File: rtl/hdc_sensor_fusion_3m1p_pkg.sv
// Shared constants, state encoding and helpers for the 3-modality HDC emotion classifier.
`timescale 1ns/1ps
package hdc_sensor_fusion_3m1p_pkg;

  localparam int HV_DIMENSION      = 2000;
  localparam int CHANNEL_WIDTH     = 2;
  localparam int NUM_GSR           = 32;
  localparam int NUM_ECG           = 77;
  localparam int NUM_EEG           = 105;
  localparam int TOTAL_NUM_CHANNEL = NUM_GSR + NUM_ECG + NUM_EEG;
  localparam int NUM_MODALITY      = 3;
  localparam int MEM_DEPTH         = 8;
  localparam int ADDR_WIDTH        = 3;
  localparam int CNT_WIDTH         = 7;

  function automatic int ceil_log2(input int value);
    int result;
    result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      result++;
    end
    return result;
  endfunction

  localparam int CH_WIDTH   = ceil_log2(TOTAL_NUM_CHANNEL);
  localparam int DIST_WIDTH = ceil_log2(HV_DIMENSION + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ENCODE,
    ST_FUSE,
    ST_AM,
    ST_DONE
  } state_t;

  typedef enum logic [1:0] {
    MOD_GSR,
    MOD_ECG,
    MOD_EEG
  } modality_t;

endpackage

// File: rtl/hdc_sensor_fusion_3m1p_am_compare.sv
// Associative-memory compare: picks prototype 1 only when it is strictly closer
// (Hamming distance) to the query than prototype 0.
`timescale 1ns/1ps
module hdc_am_compare
  import hdc_sensor_fusion_3m1p_pkg::*;
(
  input  logic [HV_DIMENSION-1:0] query,
  input  logic [HV_DIMENSION-1:0] proto_0,
  input  logic [HV_DIMENSION-1:0] proto_1,
  output logic                    label
);

  logic [DIST_WIDTH-1:0] dist_0;
  logic [DIST_WIDTH-1:0] dist_1;

  always_comb begin
    dist_0 = '0;
    dist_1 = '0;
    for (int i = 0; i < HV_DIMENSION; i++) begin
      dist_0 = dist_0 + DIST_WIDTH'(query[i] ^ proto_0[i]);
      dist_1 = dist_1 + DIST_WIDTH'(query[i] ^ proto_1[i]);
    end
  end

  assign label = dist_1 < dist_0;

endmodule

// File: rtl/hdc_sensor_fusion_3m1p.sv
// 3-modality / 1-prototype-pair HDC sensor-fusion classifier: item memory, per-channel
// encoder, majority fusion and valence/arousal associative-memory lookup.
`timescale 1ns/1ps
module hdc_sensor_fusion_3m1p
  import hdc_sensor_fusion_3m1p_pkg::*;
(
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic [TOTAL_NUM_CHANNEL*CHANNEL_WIDTH-1:0] features_top,
  input  logic                                       fin_valid,
  output logic                                       fin_ready,
  output logic                                       valence,
  output logic                                       arousal,
  output logic                                       dout_valid,
  input  logic                                       dout_ready,
  input  logic                                       write_enable_valid,
  input  logic                                       write_enable,
  input  logic [ADDR_WIDTH-1:0]                      addr_1,
  input  logic [ADDR_WIDTH-1:0]                      addr_2,
  input  logic [ADDR_WIDTH-1:0]                      addr_3,
  input  logic [HV_DIMENSION-1:0]                    hv_1,
  input  logic [HV_DIMENSION-1:0]                    hv_2,
  input  logic [HV_DIMENSION-1:0]                    hv_3
);

  localparam logic [CNT_WIDTH:0] THR_GSR = (CNT_WIDTH + 1)'(NUM_GSR);
  localparam logic [CNT_WIDTH:0] THR_ECG = (CNT_WIDTH + 1)'(NUM_ECG);
  localparam logic [CNT_WIDTH:0] THR_EEG = (CNT_WIDTH + 1)'(NUM_EEG);

  state_t state;
  state_t state_next;

  logic [CH_WIDTH-1:0]                          ch;
  logic                                         ch_last;
  logic [TOTAL_NUM_CHANNEL*CHANNEL_WIDTH-1:0]   features;
  logic                                         fin_fire;
  logic                                         mem_write;

  logic [HV_DIMENSION-1:0] bank_1 [MEM_DEPTH];
  logic [HV_DIMENSION-1:0] bank_2 [MEM_DEPTH];
  logic [HV_DIMENSION-1:0] bank_3 [MEM_DEPTH];

  modality_t               modality;
  logic                    modality_first;
  logic [CHANNEL_WIDTH-1:0] level_idx;
  logic [HV_DIMENSION-1:0] id_reg;
  logic [HV_DIMENSION-1:0] id_cur;
  logic [HV_DIMENSION-1:0] bound;

  logic [CNT_WIDTH-1:0]    cnt [NUM_MODALITY][HV_DIMENSION];
  logic [HV_DIMENSION-1:0] m_gsr;
  logic [HV_DIMENSION-1:0] m_ecg;
  logic [HV_DIMENSION-1:0] m_eeg;
  logic [HV_DIMENSION-1:0] fused_next;
  logic [HV_DIMENSION-1:0] fused;

  logic valence_next;
  logic arousal_next;

  assign fin_ready = (state == ST_IDLE) && !write_enable_valid;
  assign fin_fire  = fin_valid && fin_ready;
  assign ch_last   = ch == CH_WIDTH'(TOTAL_NUM_CHANNEL - 1);
  assign mem_write = (state == ST_IDLE) && write_enable_valid && !write_enable;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:   if (fin_fire) state_next = ST_ENCODE;
      ST_ENCODE: if (ch_last) state_next = ST_FUSE;
      ST_FUSE:   state_next = ST_AM;
      ST_AM:     state_next = ST_DONE;
      ST_DONE:   if (dout_ready) state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  // Item memory has no reset so a mid-transaction reset keeps the loaded HVs.
  always_ff @(posedge clk) begin
    if (mem_write) begin
      bank_1[addr_1] <= hv_1;
      bank_2[addr_2] <= hv_2;
      bank_3[addr_3] <= hv_3;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ch <= '0;
    end else if (fin_fire) begin
      ch <= '0;
    end else if (state == ST_ENCODE) begin
      ch <= ch + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (fin_fire) begin
      features <= features_top;
    end
  end

  always_comb begin
    modality       = MOD_GSR;
    modality_first = 1'b0;
    if (ch < CH_WIDTH'(NUM_GSR)) begin
      modality       = MOD_GSR;
      modality_first = ch == '0;
    end else if (ch < CH_WIDTH'(NUM_GSR + NUM_ECG)) begin
      modality       = MOD_ECG;
      modality_first = ch == CH_WIDTH'(NUM_GSR);
    end else begin
      modality       = MOD_EEG;
      modality_first = ch == CH_WIDTH'(NUM_GSR + NUM_ECG);
    end
  end

  // Channel ID is the modality seed rotated by the channel's position in its modality.
  assign level_idx = features[ch*CHANNEL_WIDTH +: CHANNEL_WIDTH];
  assign id_cur    = modality_first ? bank_1[{1'b0, modality}] : id_reg;
  assign bound     = id_cur ^ bank_2[ADDR_WIDTH'(level_idx)];

  always_ff @(posedge clk) begin
    if (state == ST_ENCODE) begin
      id_reg <= {id_cur[HV_DIMENSION-2:0], id_cur[HV_DIMENSION-1]};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst || fin_fire) begin
      for (int m = 0; m < NUM_MODALITY; m++) begin
        for (int i = 0; i < HV_DIMENSION; i++) begin
          cnt[m][i] <= '0;
        end
      end
    end else if (state == ST_ENCODE) begin
      for (int i = 0; i < HV_DIMENSION; i++) begin
        cnt[modality][i] <= cnt[modality][i] + CNT_WIDTH'(bound[i]);
      end
    end
  end

  // Strict majority per modality: an exact half count resolves to 0.
  always_comb begin
    m_gsr = '0;
    m_ecg = '0;
    m_eeg = '0;
    for (int i = 0; i < HV_DIMENSION; i++) begin
      m_gsr[i] = {cnt[MOD_GSR][i], 1'b0} > THR_GSR;
      m_ecg[i] = {cnt[MOD_ECG][i], 1'b0} > THR_ECG;
      m_eeg[i] = {cnt[MOD_EEG][i], 1'b0} > THR_EEG;
    end
  end

  assign fused_next = (m_gsr & m_ecg) | (m_gsr & m_eeg) | (m_ecg & m_eeg);

  always_ff @(posedge clk) begin
    if (state == ST_FUSE) begin
      fused <= fused_next;
    end
  end

  hdc_am_compare u_valence (
    .query   (fused),
    .proto_0 (bank_3[0]),
    .proto_1 (bank_3[1]),
    .label   (valence_next)
  );

  hdc_am_compare u_arousal (
    .query   (fused),
    .proto_0 (bank_3[2]),
    .proto_1 (bank_3[3]),
    .label   (arousal_next)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      dout_valid <= 1'b0;
      valence    <= 1'b0;
      arousal    <= 1'b0;
    end else begin
      dout_valid <= state_next == ST_DONE;
      if (state == ST_AM) begin
        valence <= valence_next;
        arousal <= arousal_next;
      end
    end
  end

endmodule

// File: tb/tb_hdc_sensor_fusion_3m1p.sv
// Scoreboard bench for hdc_sensor_fusion_3m1p: directed corner cases plus randomized
// traffic checked against a plain-arithmetic reference model of the classifier.
`timescale 1ns/1ps
module tb_hdc_sensor_fusion_3m1p;
  import hdc_sensor_fusion_3m1p_pkg::*;

  localparam int D       = HV_DIMENSION;
  localparam int W       = CHANNEL_WIDTH;
  localparam int N       = TOTAL_NUM_CHANNEL;
  localparam int FW      = N * W;
  localparam int LATENCY = N + 2;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [FW-1:0]         features_top;
  logic                  fin_valid;
  logic                  fin_ready;
  logic                  valence;
  logic                  arousal;
  logic                  dout_valid;
  logic                  dout_ready;
  logic                  write_enable_valid;
  logic                  write_enable;
  logic [ADDR_WIDTH-1:0] addr_1, addr_2, addr_3;
  logic [D-1:0]          hv_1, hv_2, hv_3;

  logic [D-1:0] ref_seed  [3];
  logic [D-1:0] ref_level [4];
  logic [D-1:0] ref_proto [4];

  logic [1:0] exp_q [$];
  int         acc_q [$];
  int         cyc = 0;
  int         errors = 0;
  int         checks = 0;
  logic       prev_dv = 1'b0;
  logic [1:0] exp_lab;
  int         t_acc;

  hdc_sensor_fusion_3m1p dut (
    .clk                (clk),
    .rst                (rst),
    .features_top       (features_top),
    .fin_valid          (fin_valid),
    .fin_ready          (fin_ready),
    .valence            (valence),
    .arousal            (arousal),
    .dout_valid         (dout_valid),
    .dout_ready         (dout_ready),
    .write_enable_valid (write_enable_valid),
    .write_enable       (write_enable),
    .addr_1             (addr_1),
    .addr_2             (addr_2),
    .addr_3             (addr_3),
    .hv_1               (hv_1),
    .hv_2               (hv_2),
    .hv_3               (hv_3)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_output(input string name, input int got, input int expected);
    checks++;
    if (got !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, got, expected, cyc);
    end
  endtask

  task automatic step_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reference model: bind rotated seed with level HV per channel, count, threshold, fuse, compare.
  function automatic logic [1:0] model(input logic [FW-1:0] f);
    int           cnt [D];
    logic [D-1:0] mhv [3];
    logic [D-1:0] fz;
    int           base;
    int           n;
    int           lvl;
    base = 0;
    for (int m = 0; m < 3; m++) begin
      n = (m == 0) ? NUM_GSR : (m == 1) ? NUM_ECG : NUM_EEG;
      for (int i = 0; i < D; i++) cnt[i] = 0;
      for (int j = 0; j < n; j++) begin
        lvl = int'(f[(base + j)*W +: W]);
        for (int i = 0; i < D; i++) begin
          cnt[i] += int'(ref_seed[m][(i - j + D) % D] ^ ref_level[lvl][i]);
        end
      end
      for (int i = 0; i < D; i++) mhv[m][i] = (2 * cnt[i]) > n;
      base += n;
    end
    fz = (mhv[0] & mhv[1]) | (mhv[0] & mhv[2]) | (mhv[1] & mhv[2]);
    return {($countones(fz ^ ref_proto[1]) < $countones(fz ^ ref_proto[0])),
            ($countones(fz ^ ref_proto[3]) < $countones(fz ^ ref_proto[2]))};
  endfunction

  function automatic logic [D-1:0] rand_hv();
    logic [D-1:0] v;
    for (int i = 0; i < D; i++) v[i] = 1'($urandom_range(0, 1));
    return v;
  endfunction

  function automatic logic [FW-1:0] rand_features();
    logic [FW-1:0] f;
    for (int c = 0; c < N; c++) f[c*W +: W] = W'($urandom_range(0, 3));
    return f;
  endfunction

  task automatic load_mem();
    write_enable_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      addr_1 = ADDR_WIDTH'(k);
      addr_2 = ADDR_WIDTH'(k);
      addr_3 = ADDR_WIDTH'(k);
      if (k < 3) hv_1 = ref_seed[k];
      else hv_1 = '0;
      hv_2 = ref_level[k];
      hv_3 = ref_proto[k];
      write_enable = 1'b0;
      step_cycles(1);
    end
    write_enable       = 1'b1;
    write_enable_valid = 1'b0;
    step_cycles(1);
  endtask

  task automatic apply_stimulus(input logic [FW-1:0] f, input logic [1:0] expected);
    int waited;
    waited       = 0;
    features_top = f;
    fin_valid    = 1'b1;
    @(negedge clk);
    while (!fin_ready && waited < 3000) begin
      @(negedge clk);
      waited++;
    end
    if (!fin_ready) begin
      check_output("fin_accept_timeout", 0, 1);
      fin_valid = 1'b0;
      return;
    end
    exp_q.push_back(expected);
    acc_q.push_back(cyc + 1);
    step_cycles(1);
    fin_valid = 1'b0;
  endtask

  task automatic wait_output();
    int waited;
    waited = 0;
    @(negedge clk);
    while (!dout_valid && waited < 1000) begin
      @(negedge clk);
      waited++;
    end
    if (!dout_valid) check_output("dout_valid_timeout", 0, 1);
    step_cycles(1);
  endtask

  // Monitor: latency on each dout_valid rise, labels on each output handshake.
  always @(negedge clk) begin
    if (rst) begin
      if (dout_valid && !prev_dv) begin
        if (acc_q.size() == 0) begin
          check_output("latency_orphan", 1, 0);
        end else begin
          t_acc = acc_q.pop_front();
          check_output("latency", cyc - t_acc, LATENCY);
        end
      end
      if (dout_valid && dout_ready) begin
        if (exp_q.size() == 0) begin
          check_output("labels_orphan", 1, 0);
        end else begin
          exp_lab = exp_q.pop_front();
          check_output("labels", int'({valence, arousal}), int'(exp_lab));
        end
      end
    end
    prev_dv = dout_valid;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [FW-1:0] f;
    int            bad;
    rst                = 1'b0;
    fin_valid          = 1'b0;
    dout_ready         = 1'b1;
    write_enable_valid = 1'b0;
    write_enable       = 1'b1;
    addr_1 = '0; addr_2 = '0; addr_3 = '0;
    hv_1 = '0; hv_2 = '0; hv_3 = '0;
    features_top = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check_output("reset_fin_ready", int'(fin_ready), 1);
    check_output("reset_dout_valid", int'(dout_valid), 0);
    check_output("reset_valence", int'(valence), 0);
    check_output("reset_arousal", int'(arousal), 0);
    step_cycles(1);

    // All-zero memories and features: equal distances give 0/0.
    for (int k = 0; k < 3; k++) ref_seed[k] = '0;
    for (int k = 0; k < 4; k++) begin ref_level[k] = '0; ref_proto[k] = '0; end
    load_mem();
    apply_stimulus('0, 2'b00);
    wait_output();

    // L0 all-ones with zero seeds makes every bound HV all-ones.
    ref_level[0] = '1;
    ref_proto[1] = '1;
    ref_proto[3] = '1;
    load_mem();
    apply_stimulus('0, 2'b11);
    wait_output();

    // Every channel at level 1 (L1 = 0) fuses to zero; output held under backpressure.
    for (int c = 0; c < N; c++) f[c*W +: W] = W'(1);
    dout_ready = 1'b0;
    apply_stimulus(f, 2'b00);
    wait_output();
    bad = 0;
    repeat (50) begin
      @(negedge clk);
      if ({dout_valid, valence, arousal, fin_ready} !== 4'b1000) bad++;
    end
    check_output("hold_outputs_bad_cycles", bad, 0);
    step_cycles(1);
    dout_ready = 1'b1;
    step_cycles(2);

    // Load mode blocks input; writing unused address 7 must not disturb results.
    write_enable_valid = 1'b1;
    fin_valid          = 1'b1;
    features_top       = '0;
    bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (fin_ready !== 1'b0) bad++;
    end
    check_output("fin_ready_blocked_bad_cycles", bad, 0);
    step_cycles(1);
    fin_valid = 1'b0;
    addr_1 = 3'd7; addr_2 = 3'd7; addr_3 = 3'd7;
    hv_1 = '0; hv_2 = '0; hv_3 = '0;
    write_enable = 1'b0;
    step_cycles(1);
    write_enable       = 1'b1;
    write_enable_valid = 1'b0;
    step_cycles(1);
    apply_stimulus('0, 2'b11);
    wait_output();

    // Random memories; reset mid-encode, then rerun without reloading.
    for (int k = 0; k < 3; k++) ref_seed[k] = rand_hv();
    for (int k = 0; k < 4; k++) begin ref_level[k] = rand_hv(); ref_proto[k] = rand_hv(); end
    load_mem();
    f = rand_features();
    apply_stimulus(f, model(f));
    step_cycles(99);
    rst = 1'b0;
    step_cycles(1);
    rst = 1'b1;
    exp_q.delete();
    acc_q.delete();
    @(negedge clk);
    check_output("midreset_dout_valid", int'(dout_valid), 0);
    check_output("midreset_fin_ready", int'(fin_ready), 1);
    check_output("midreset_valence", int'(valence), 0);
    check_output("midreset_arousal", int'(arousal), 0);
    step_cycles(1);
    apply_stimulus(f, model(f));
    wait_output();

    // Ten randomized transactions with random input and output gaps.
    dout_ready = 1'b0;
    fork
      begin
        logic [FW-1:0] rf;
        for (int k = 0; k < 10; k++) begin
          step_cycles($urandom_range(0, 127));
          rf = rand_features();
          apply_stimulus(rf, model(rf));
        end
      end
      begin
        int waited;
        for (int k = 0; k < 10; k++) begin
          waited = 0;
          @(negedge clk);
          while (!dout_valid && waited < 2000) begin
            @(negedge clk);
            waited++;
          end
          if (!dout_valid) begin
            check_output("random_dout_timeout", 0, 1);
            break;
          end
          step_cycles(1 + $urandom_range(0, 127));
          dout_ready = 1'b1;
          step_cycles(1);
          dout_ready = 1'b0;
        end
      end
    join

    step_cycles(5);
    check_output("scoreboard_drain", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
